// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: CPU byte cycles with ready handshake, DMA hold/hlda
// read ownership, plus sticky DMA-protocol and hold-starvation flags.
module vram_arbiter #(
  parameter int HOLD_MAX   = 1024,
  parameter int HOLD_CNT_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  input  logic        cpu_rw,
  input  logic        cpu_cs,
  output logic        cpu_ready,
  input  logic        hold,
  input  logic [15:0] VADDR,
  input  logic        vramcs,
  output logic [7:0]  VDATA,
  output logic        vrambusy,
  output logic        hlda,
  output logic        dma_err,
  output logic        hold_ovf,
  input  logic        err_clr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_ce,
  output logic        mem_we
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    CPU_ACK = 2'd2,
    DMA_GNT = 2'd3
  } state_e;

  localparam logic [HOLD_CNT_W-1:0] CntMax   = HOLD_CNT_W'(HOLD_MAX);
  localparam logic [HOLD_CNT_W-1:0] CntLast  = HOLD_CNT_W'(HOLD_MAX - 1);
  localparam logic [HOLD_CNT_W-1:0] CntOne   = HOLD_CNT_W'(1);

  state_e                  state_q, state_d;
  logic [7:0]              cpu_do_q, cpu_do_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic                    hlda_q, hlda_d;
  logic                    dma_err_q, dma_err_d;
  logic                    hold_ovf_q, hold_ovf_d;
  logic [HOLD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    err_set_s, ovf_set_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cpu_do_q    <= 8'h00;
      cpu_ready_q <= 1'b0;
      hlda_q      <= 1'b0;
      dma_err_q   <= 1'b0;
      hold_ovf_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cpu_do_q    <= cpu_do_d;
      cpu_ready_q <= cpu_ready_d;
      hlda_q      <= hlda_d;
      dma_err_q   <= dma_err_d;
      hold_ovf_q  <= hold_ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cpu_do_d = cpu_do_q;
    mem_addr = cpu_addr;
    mem_ce   = 1'b0;
    mem_we   = 1'b0;
    VDATA    = 8'h00;
    case (state_q)
      IDLE: begin
        // DMA wins a tie with the CPU
        if (hold) begin
          state_d = DMA_GNT;
        end else if (cpu_cs) begin
          state_d = CPU_ACC;
        end else begin
          state_d = IDLE;
        end
      end
      CPU_ACC: begin
        mem_ce  = 1'b1;
        mem_we  = ~cpu_rw;
        state_d = CPU_ACK;
        if (cpu_rw) begin
          cpu_do_d = mem_din;
        end else begin
          cpu_do_d = cpu_do_q;
        end
      end
      CPU_ACK: begin
        state_d = hold ? DMA_GNT : IDLE;
      end
      DMA_GNT: begin
        mem_addr = VADDR;
        mem_ce   = vramcs;
        VDATA    = mem_din;
        state_d  = hold ? DMA_GNT : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready and hlda are registered versions of the state being entered
    cpu_ready_d = (state_d == CPU_ACK);
    hlda_d      = (state_d == DMA_GNT);

    if (state_q != DMA_GNT) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntOne;
    end else begin
      cnt_d = cnt_q;
    end

    ovf_set_s  = (state_q == DMA_GNT) && (cnt_q >= CntLast);
    err_set_s  = vramcs && (state_q != DMA_GNT);
    dma_err_d  = err_set_s | (dma_err_q & ~err_clr);
    hold_ovf_d = ovf_set_s | (hold_ovf_q & ~err_clr);
  end

  assign cpu_do    = cpu_do_q;
  assign cpu_ready = cpu_ready_q;
  assign hlda      = hlda_q;
  assign dma_err   = dma_err_q;
  assign hold_ovf  = hold_ovf_q;
  assign mem_dout  = cpu_di;
  assign vrambusy  = (state_q == CPU_ACC) || (state_q == CPU_ACK);

endmodule
